// File: rtl/alu_share_arb_pkg.sv
// Shared types and helpers for the round-robin ALU sharing arbiter.
// The ALU command encodings match the mips_16 ALU.
package alu_arb_pkg;

   localparam int ALU_CMD_W = 3;
   localparam int MAX_REQ   = 8;
   localparam int PTR_W     = 3;

   localparam logic [ALU_CMD_W-1:0] ALU_NC  = 3'd0;
   localparam logic [ALU_CMD_W-1:0] ALU_ADD = 3'd1;
   localparam logic [ALU_CMD_W-1:0] ALU_SUB = 3'd2;
   localparam logic [ALU_CMD_W-1:0] ALU_AND = 3'd3;
   localparam logic [ALU_CMD_W-1:0] ALU_OR  = 3'd4;
   localparam logic [ALU_CMD_W-1:0] ALU_XOR = 3'd5;
   localparam logic [ALU_CMD_W-1:0] ALU_SL  = 3'd6;
   localparam logic [ALU_CMD_W-1:0] ALU_SRU = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // First asserted valid at or after ptr, wrapping within the n live requesters.
   function automatic logic [PTR_W-1:0] next_rr(input logic [PTR_W-1:0] ptr,
                                                input logic [MAX_REQ-1:0] valid,
                                                input int unsigned n);
      logic [PTR_W-1:0] win;
      logic             found;
      int unsigned      idx;
      win   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= n) begin
            idx = idx - n;
         end else begin
            idx = idx;
         end
         if (i < n && !found && valid[idx[PTR_W-1:0]]) begin
            win   = idx[PTR_W-1:0];
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bus between the requesters and the shared-ALU arbiter.
interface alu_share_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 3
) ();
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [3*NUM_REQ-1:0]  req_cmd;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [15:0]           resp_r;
   logic                  busy;

   modport master (
      output req_valid, req_a, req_b, req_cmd, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_r, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cmd, resp_ready,
      output req_ready, resp_valid, resp_id, resp_r, busy
   );
endinterface

// File: rtl/alu_share_arb_alu.sv
// mips_16 16-bit ALU: purely combinational, unknown commands yield zero.
module alu
   import alu_arb_pkg::*;
(
   input  logic [15:0]          a,
   input  logic [15:0]          b,
   input  logic [ALU_CMD_W-1:0] cmd,
   output logic [15:0]          r
);

   // Function decode; shifts use the low four bits of b.
   always_comb begin
      r = 16'h0000;
      case (cmd)
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SL:  r = a << b[3:0];
         ALU_SRU: r = a >> b[3:0];
         default: r = 16'h0000;
      endcase
   end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one ALU between NUM_REQ requesters,
// sequencing IDLE -> EXEC -> RESP with a registered, backpressured result.
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 3
) (
   input  logic           clk,
   input  logic           rst,
   alu_share_arb_if.slave bus
);

   state_e               state_r;
   logic [PTR_W-1:0]     rr_ptr_r;
   logic [PTR_W-1:0]     id_r;
   logic [15:0]          a_r;
   logic [15:0]          b_r;
   logic [ALU_CMD_W-1:0] cmd_r;
   logic [15:0]          resp_r_r;
   logic [IDW-1:0]       resp_id_r;
   logic                 resp_valid_r;
   logic                 busy_r;

   logic [MAX_REQ-1:0]   valid_s;
   logic [PTR_W-1:0]     win_s;
   logic                 any_s;
   logic [NUM_REQ-1:0]   ready_s;
   logic [15:0]          a_sel_s;
   logic [15:0]          b_sel_s;
   logic [ALU_CMD_W-1:0] cmd_sel_s;
   logic [15:0]          alu_r_s;

   assign valid_s = MAX_REQ'(bus.req_valid);
   assign any_s   = |bus.req_valid;
   assign win_s   = next_rr(rr_ptr_r, valid_s, NUM_REQ);

   // Grant decode and operand mux for the current round-robin winner.
   always_comb begin
      ready_s   = '0;
      a_sel_s   = 16'h0000;
      b_sel_s   = 16'h0000;
      cmd_sel_s = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_s == PTR_W'(i)) begin
            ready_s[i] = (state_r == IDLE) && rst && any_s;
            a_sel_s    = bus.req_a[16*i +: 16];
            b_sel_s    = bus.req_b[16*i +: 16];
            cmd_sel_s  = bus.req_cmd[3*i +: 3];
         end else begin
            ready_s[i] = 1'b0;
         end
      end
   end

   alu u_alu (
      .a   (a_r),
      .b   (b_r),
      .cmd (cmd_r),
      .r   (alu_r_s)
   );

   // Sequencer: capture the winner, run the ALU once, hold the result until taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         rr_ptr_r     <= '0;
         id_r         <= '0;
         a_r          <= 16'h0000;
         b_r          <= 16'h0000;
         cmd_r        <= 3'd0;
         resp_r_r     <= 16'h0000;
         resp_id_r    <= '0;
         resp_valid_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_s) begin
                  a_r     <= a_sel_s;
                  b_r     <= b_sel_s;
                  cmd_r   <= cmd_sel_s;
                  id_r    <= win_s;
                  busy_r  <= 1'b1;
                  state_r <= EXEC;
               end else begin
                  state_r <= IDLE;
               end
            end
            EXEC: begin
               // ALU_NC is forced to zero so the result is never X after synthesis.
               resp_r_r     <= (cmd_r == ALU_NC) ? 16'h0000 : alu_r_s;
               resp_id_r    <= IDW'(id_r);
               resp_valid_r <= 1'b1;
               rr_ptr_r     <= (id_r == PTR_W'(NUM_REQ - 1)) ? '0 : id_r + 3'd1;
               state_r      <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
                  state_r      <= IDLE;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               resp_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_id    = resp_id_r;
   assign bus.resp_r     = resp_r_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: per-requester job queues feed the DUT, a model
// predicts grants and results, and directed phases pin literal values.
module tb_alu_share_arb;
   import alu_arb_pkg::*;

   localparam int NR = 2;
   localparam int IW = 3;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  cmd;
   } job_t;

   typedef struct packed {
      logic [2:0]  id;
      logic [15:0] r;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_share_arb_if #(.NUM_REQ(NR), .IDW(IW)) bus ();

   alu_share_arb #(.NUM_REQ(NR), .IDW(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   errors = 0;
   job_t jq0[$];
   job_t jq1[$];
   rsp_t exp_q[$];
   rsp_t resp_log[$];
   int   grant_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mdl_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] c);
      case (c)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SL:  return a << b[3:0];
         ALU_SRU: return a >> b[3:0];
         default: return 16'h0000;
      endcase
   endfunction

   function automatic int mdl_win(input int nxt, input logic [NR-1:0] v);
      for (int k = 0; k < NR; k++) begin
         if (v[(nxt + k) % NR]) return (nxt + k) % NR;
      end
      return -1;
   endfunction

   // Requester driver: presents queued jobs, holds them until accepted.
   initial begin
      logic [NR-1:0] hs;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cmd   = '0;
      forever begin
         @(negedge clk);
         hs = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         if (hs[0]) begin
            bus.req_valid[0] = 1'b0;
            void'(jq0.pop_front());
         end
         if (hs[1]) begin
            bus.req_valid[1] = 1'b0;
            void'(jq1.pop_front());
         end
         if (!bus.req_valid[0] && jq0.size() != 0) begin
            bus.req_a[15:0]  = jq0[0].a;
            bus.req_b[15:0]  = jq0[0].b;
            bus.req_cmd[2:0] = jq0[0].cmd;
            bus.req_valid[0] = 1'b1;
         end
         if (!bus.req_valid[1] && jq1.size() != 0) begin
            bus.req_a[31:16] = jq1[0].a;
            bus.req_b[31:16] = jq1[0].b;
            bus.req_cmd[5:3] = jq1[0].cmd;
            bus.req_valid[1] = 1'b1;
         end
      end
   end

   // Compare process: model of grants, results, latency and busy every cycle.
   initial begin
      int            w;
      int            mdl_next;
      int            since;
      logic          prev_rv;
      logic [NR-1:0] er;
      logic [15:0]   ma, mb;
      logic [2:0]    mc;
      mdl_next = 0;
      since    = 99;
      prev_rv  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            mdl_next = 0;
            since    = 99;
            prev_rv  = 1'b0;
         end else begin
            since = (since < 99) ? since + 1 : since;
            chk("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               chk("ready_while_busy", 32'(bus.req_ready), 32'd0);
            end else begin
               w  = mdl_win(mdl_next, bus.req_valid);
               er = (w < 0) ? '0 : NR'(1 << w);
               chk("ready_grant", 32'(bus.req_ready), 32'(er));
            end
            if (bus.resp_valid) begin
               if (exp_q.size() == 0) begin
                  chk("resp_pending", 32'(exp_q.size()), 32'd1);
               end else begin
                  chk("resp_id", 32'(bus.resp_id), 32'(exp_q[0].id));
                  chk("resp_r", 32'(bus.resp_r), 32'(exp_q[0].r));
               end
               if (!prev_rv) chk("latency", 32'(since), 32'd2);
            end
            if (bus.resp_valid && bus.resp_ready && exp_q.size() != 0) begin
               resp_log.push_back('{id: bus.resp_id, r: bus.resp_r});
               void'(exp_q.pop_front());
            end else if (exp_q.size() == 0 && (bus.req_valid & bus.req_ready) != '0) begin
               w  = mdl_win(mdl_next, bus.req_valid);
               ma = bus.req_a[16*w +: 16];
               mb = bus.req_b[16*w +: 16];
               mc = bus.req_cmd[3*w +: 3];
               exp_q.push_back('{id: 3'(w), r: mdl_alu(ma, mb, mc)});
               grant_log.push_back(w);
               mdl_next = (w + 1) % NR;
               since    = 0;
            end
            prev_rv = bus.resp_valid;
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_rid"}, 32'(bus.resp_id), 32'd0);
      chk({tag, "_rr"}, 32'(bus.resp_r), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      @(posedge clk);
      #3;
      while ((jq0.size() != 0 || jq1.size() != 0 || exp_q.size() != 0 || bus.req_valid != '0)
             && n < 200) begin
         n++;
         @(posedge clk);
         #3;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s: drain timeout after %0d cycles, required completion", name, n);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int gb;
      int n;
      bus.resp_ready = 1'b1;
      rst = 1'b0;
      #23;
      check_zero("rst");
      #4 rst = 1'b1;

      // Lone requester 0: ADD 3 + 4.
      base = resp_log.size();
      jq0.push_back('{a: 16'h0003, b: 16'h0004, cmd: ALU_ADD});
      wait_drain("p1");
      chk("p1_count", 32'(resp_log.size() - base), 32'd1);
      chk("p1_r", 32'(resp_log[base].r), 32'h0007);
      chk("p1_id", 32'(resp_log[base].id), 32'd0);

      // Reset so both requesters start from rr_ptr = 0.
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_zero("rst2");
      @(posedge clk);
      #3 rst = 1'b1;

      // Both requesters contend: grants must alternate.
      base = resp_log.size();
      gb   = grant_log.size();
      jq0.push_back('{a: 16'h0005, b: 16'h0007, cmd: ALU_SUB});
      jq0.push_back('{a: 16'h1234, b: 16'h0101, cmd: ALU_ADD});
      jq0.push_back('{a: 16'hAAAA, b: 16'h0F0F, cmd: ALU_AND});
      jq0.push_back('{a: 16'h1000, b: 16'h0001, cmd: ALU_OR});
      jq1.push_back('{a: 16'hFF00, b: 16'h0FF0, cmd: ALU_XOR});
      jq1.push_back('{a: 16'h0000, b: 16'h0001, cmd: ALU_SUB});
      jq1.push_back('{a: 16'h00FF, b: 16'h0003, cmd: ALU_SL});
      jq1.push_back('{a: 16'h0F0F, b: 16'hF0F0, cmd: ALU_OR});
      wait_drain("p2");
      chk("p2_count", 32'(resp_log.size() - base), 32'd8);
      chk("p2_r0", 32'(resp_log[base].r), 32'hFFFE);
      chk("p2_id0", 32'(resp_log[base].id), 32'd0);
      chk("p2_r1", 32'(resp_log[base+1].r), 32'hF0F0);
      chk("p2_id1", 32'(resp_log[base+1].id), 32'd1);
      chk("p2_r2", 32'(resp_log[base+2].r), 32'h1335);
      chk("p2_r3", 32'(resp_log[base+3].r), 32'hFFFF);
      for (int k = 0; k < 8; k++) begin
         chk("p2_grant", 32'(grant_log[gb+k]), 32'(k % 2));
      end

      // Response backpressure for 5 cycles.
      base = resp_log.size();
      bus.resp_ready = 1'b0;
      jq0.push_back('{a: 16'hF0F0, b: 16'h3C3C, cmd: ALU_AND});
      jq1.push_back('{a: 16'h0F00, b: 16'h00F0, cmd: ALU_OR});
      n = 0;
      @(posedge clk);
      #3;
      while (!bus.resp_valid && n < 50) begin
         n++;
         @(posedge clk);
         #3;
      end
      chk("p3_valid_seen", 32'(bus.resp_valid), 32'd1);
      repeat (5) begin
         @(posedge clk);
         #3;
         chk("p3_hold_valid", 32'(bus.resp_valid), 32'd1);
         chk("p3_hold_r", 32'(bus.resp_r), 32'h3030);
         chk("p3_hold_id", 32'(bus.resp_id), 32'd0);
         chk("p3_hold_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.resp_ready = 1'b1;
      wait_drain("p3");
      chk("p3_count", 32'(resp_log.size() - base), 32'd2);
      chk("p3_r1", 32'(resp_log[base+1].r), 32'h0FF0);
      chk("p3_id1", 32'(resp_log[base+1].id), 32'd1);

      // Async reset while requester 1 is in EXEC (rr_ptr would otherwise favour 1).
      jq0.push_back('{a: 16'h0001, b: 16'h0001, cmd: ALU_ADD});
      wait_drain("p4a");
      jq1.push_back('{a: 16'h0002, b: 16'h0002, cmd: ALU_ADD});
      n = 0;
      @(posedge clk);
      #3;
      while (!(bus.busy && !bus.resp_valid) && n < 50) begin
         n++;
         @(posedge clk);
         #3;
      end
      chk("p4_in_exec", 32'(bus.busy), 32'd1);
      #1 rst = 1'b0;
      #1 check_zero("p4_rst");
      @(posedge clk);
      #3 rst = 1'b1;
      base = resp_log.size();
      gb   = grant_log.size();
      jq0.push_back('{a: 16'h0009, b: 16'h0003, cmd: ALU_SUB});
      jq1.push_back('{a: 16'hFFFF, b: 16'h0001, cmd: ALU_ADD});
      wait_drain("p4b");
      chk("p4_first_grant", 32'(grant_log[gb]), 32'd0);
      chk("p4_r0", 32'(resp_log[base].r), 32'h0006);
      chk("p4_r1", 32'(resp_log[base+1].r), 32'h0000);
      chk("p4_id1", 32'(resp_log[base+1].id), 32'd1);

      // Shifts through the arbiter.
      base = resp_log.size();
      jq0.push_back('{a: 16'h0001, b: 16'h0004, cmd: ALU_SL});
      jq1.push_back('{a: 16'h8000, b: 16'h0001, cmd: ALU_SRU});
      wait_drain("p5");
      chk("p5_sl", 32'(resp_log[base].r), 32'h0010);
      chk("p5_sru", 32'(resp_log[base+1].r), 32'h4000);
      chk("p5_sru_id", 32'(resp_log[base+1].id), 32'd1);

      // ALU_NC returns zero and leaves no X behind.
      base = resp_log.size();
      jq0.push_back('{a: 16'h1234, b: 16'h1111, cmd: ALU_NC});
      wait_drain("p6");
      chk("p6_count", 32'(resp_log.size() - base), 32'd1);
      chk("p6_nc", 32'(resp_log[base].r), 32'h0000);
      chk("p6_no_x", 32'($isunknown({bus.req_ready, bus.resp_valid, bus.resp_id,
                                      bus.resp_r, bus.busy})), 32'd0);
      chk("p6_idle", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one mips_16 `alu` instance between NUM_REQ requesters, e.g. the EX stage and a multi-cycle helper unit.
- Each requester issues an operation (a, b, cmd) over a valid/ready handshake.
- The block captures the operands, drives the ALU for one cycle, and returns the registered result to the winning requester over a valid/ready response handshake with backpressure.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- IDW, 3: width of the requester tag; must satisfy 2^IDW >= NUM_REQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  16*NUM_REQ  flattened src1; slice i is requester i.
- req_b  in  16*NUM_REQ  flattened src2.
- req_cmd  in  3*NUM_REQ  flattened ALU function select, using the `ALU_* encodings from mips_16_defs.v.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_r  out  16  ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_r=0, busy=0.
  - Operand registers are cleared to 0.
  - If reset asserts mid-operation, the in-flight result is lost; requesters must reissue.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Select the winner combinationally: first asserted req_valid at or after rr_ptr, searching with wrap-around.
  - req_ready[winner]=1 only in IDLE; all other ready bits are 0.
  - On a handshake (req_valid&req_ready), latch a, b, cmd and winner id; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (1 cycle):
  - Registered operands drive the `alu` instance.
  - Capture alu.r into resp_r and set resp_valid=1 at the clock edge; go to RESP.
  - Advance rr_ptr to winner+1, wrapping to 0 after NUM_REQ-1.
- RESP:
  - Hold resp_valid, resp_id and resp_r stable until resp_ready=1.
  - On that edge clear resp_valid and go to IDLE.
- Latency:
  - Request accept to resp_valid is 2 edges.
  - Peak throughput is one operation per 3 cycles.
  - resp_ready may be held high; no combinational path exists from resp_ready to req_ready.
- Fairness:
  - A continuously requesting requester is served within NUM_REQ grants.
  - A single lone requester is served back-to-back every 3 cycles.
- Simultaneous requests: the rr_ptr rule alone decides the winner. Losers keep req_valid high and their operands stable; they are not dropped.
- cmd=`ALU_NC:
  - Passed to the ALU like any other cmd.
  - resp_r is don't-care in RTL simulation but must not be X after synthesis; the implementation forces resp_r=0 for `ALU_NC.
- Out-of-range cmd: forwarded unchanged; resp_r is whatever the ALU returns (0).
- req_valid must not drop before ready; any request withdrawn in IDLE before acceptance is simply ignored.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE, EXEC, RESP).
  - Function next_rr(ptr, valid) returning the winner index.
  - The ALU cmd width constant.
- The `ALU_* encodings stay in mips_16_defs.v.
- One sub-module, the existing `alu`, is instantiated once; arbitration is kept inline.

Test Plan:
- Requester 0 only: a=0x0003, b=0x0004, cmd=`ALU_ADD -> req_ready[0] in cycle 0; resp_valid at cycle 2 with resp_r=0x0007, resp_id=0.
- Both requesters valid from reset: r0 SUB 0x0005-0x0007, r1 XOR 0xFF00^0x0FF0 -> r0 served first (resp_r=0xFFFE), then r1 (resp_r=0xF0F0, id=1); grants alternate 0,1,0,1 over 8 operations.
- Response backpressure: resp_ready low for 5 cycles -> resp_valid, resp_r and resp_id stable; req_ready stays 0 throughout; the new grant comes only after the RESP handshake.
- Async reset during EXEC: rst pulsed low mid-cycle -> all outputs 0 immediately, state=IDLE, rr_ptr=0; the next request completes normally.
- Shift ops via arbiter: a=0x0001, b=4, cmd=`ALU_SL -> 0x0010; a=0x8000, b=1, cmd=`ALU_SRU -> 0x4000.
- `ALU_NC issued -> resp_r=0x0000; no X on any output; the FSM returns to IDLE.
